// File: rtl/pmd901_pkg.sv
// Shared types and arithmetic helpers for the PMD901 speed-ramp command stage.
package pmd901_pkg;

  typedef logic signed [15:0] speed_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STOP = 2'd2
  } ramp_state_e;

  // Result stays 17-bit so a large max_step can never wrap the step value.
  function automatic logic signed [16:0] sat_step(input logic signed [16:0] diff,
                                                  input logic [15:0] max_step);
    logic signed [16:0] lim;
    lim = $signed({1'b0, max_step});
    if (diff > lim) return lim;
    if (diff < -lim) return -lim;
    return diff;
  endfunction

  function automatic speed_t clamp_speed(input speed_t s, input logic [15:0] limit);
    logic signed [16:0] lim;
    logic signed [16:0] neg;
    logic signed [16:0] s17;
    lim = $signed({1'b0, limit});
    neg = -lim;
    s17 = $signed({s[15], s});
    if (s17 > lim) return lim[15:0];
    if (s17 < neg) return neg[15:0];
    return s;
  endfunction

endpackage

// File: rtl/pmd901_tick_gen.sv
// Free-running step-cadence counter; emits a one-cycle tick every STEP_PERIOD clocks.
module pmd901_tick_gen #(
  parameter logic [15:0] STEP_PERIOD = 16'd10000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == STEP_PERIOD - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pmd901_speed_ramp.sv
// Clamps and slew-limits signed speed targets, issuing one register write per ramp step,
// with an emergency-stop path that ramps to zero and blocks new commands.
module pmd901_speed_ramp
  import pmd901_pkg::*;
#(
  parameter logic [15:0] STEP_PERIOD = 16'd10000,
  parameter logic [15:0] MAX_STEP    = 16'd64,
  parameter logic [15:0] SPEED_LIMIT = 16'd30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_speed,
  input  logic        estop,
  output logic [15:0] wdata,
  output logic        we,
  output logic        at_target,
  output logic        busy
);

  // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready;
  // cmd_ready never depends on cmd_valid, and estop always blocks acceptance.

  ramp_state_e        state, state_nxt;
  speed_t             cur, tgt, cur_nxt, tgt_nxt;
  logic signed [16:0] diff, step, sum;
  logic               tick, accept, do_step, sync_pend, we_step;

  pmd901_tick_gen #(.STEP_PERIOD(STEP_PERIOD)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cmd_ready = !rst && !estop && (state != STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  // The post-reset sync write appears on the first cycle with rst low.
  assign we        = we_step | (sync_pend & ~rst);

  always_comb begin
    diff    = $signed({tgt[15], tgt}) - $signed({cur[15], cur});
    step    = sat_step(diff, MAX_STEP);
    sum     = $signed({cur[15], cur}) + step;
    do_step = tick && (cur != tgt);
    cur_nxt = do_step ? sum[15:0] : cur;
    tgt_nxt = tgt;
    if (estop || state == STOP) begin
      tgt_nxt = '0;
    end else if (accept) begin
      tgt_nxt = clamp_speed($signed(cmd_speed), SPEED_LIMIT);
    end
  end

  always_comb begin
    state_nxt = state;
    if (estop) begin
      state_nxt = STOP;
    end else begin
      case (state)
        IDLE:    if (cur != tgt) state_nxt = RAMP;
        RAMP:    if (cur == tgt) state_nxt = IDLE;
        STOP:    if (cur == '0)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      tgt       <= '0;
      wdata     <= '0;
      we_step   <= 1'b0;
      at_target <= 1'b1;
      sync_pend <= 1'b1;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      tgt       <= tgt_nxt;
      we_step   <= do_step;
      if (do_step) wdata <= cur_nxt;
      at_target <= (cur_nxt == tgt_nxt);
      sync_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmd901_speed_ramp.sv
// Directed and randomized bench for pmd901_speed_ramp against an arithmetic reference model.
module tb_pmd901_speed_ramp;

  localparam int P  = 4;
  localparam int MS = 100;
  localparam int SL = 1000;

  logic               clk = 1'b0;
  logic               rst, cmd_valid, estop;
  logic [15:0]        cmd_speed;
  logic               cmd_ready, we, at_target, busy;
  logic signed [15:0] wdata;

  pmd901_speed_ramp #(
    .STEP_PERIOD(16'd4),
    .MAX_STEP   (16'd100),
    .SPEED_LIMIT(16'd1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_speed (cmd_speed),
    .estop     (estop),
    .wdata     (wdata),
    .we        (we),
    .at_target (at_target),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: speeds as plain integers, phase as cycles since reset.
  int m_cur, m_tgt, m_k, m_wdata;
  bit m_we, m_sync, m_stop, m_busy;

  int obs_q[$];
  int wr_cyc[$];
  int exp_q[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic cycle(input bit r, input bit v, input int spd, input bit es, input bit do_chk = 1'b1);
    bit tick, acc, new_stop;
    int new_cur, new_tgt;
    rst = r; cmd_valid = v; cmd_speed = spd[15:0]; estop = es;
    #1;
    if (do_chk) begin
      chk("we", we, m_we || (m_sync && !r));
      chk("wdata", wdata, m_wdata);
      chk("cmd_ready", cmd_ready, !r && !es && !m_stop);
      chk("at_target", at_target, m_cur == m_tgt);
      chk("busy", busy, m_busy);
    end
    if (we === 1'b1 && !r) begin
      obs_q.push_back(int'(wdata));
      wr_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (r) begin
      m_cur = 0; m_tgt = 0; m_k = 0; m_wdata = 0;
      m_we = 0; m_sync = 1; m_stop = 0; m_busy = 0;
    end else begin
      tick     = (m_k == P - 1);
      acc      = v && !es && !m_stop;
      new_cur  = m_cur;
      m_we     = tick && (m_cur != m_tgt);
      if (m_we) begin
        new_cur = m_cur + clampi(m_tgt - m_cur, MS);
        m_wdata = new_cur;
      end
      m_busy   = es || (m_stop ? (m_cur != 0) : (m_cur != m_tgt));
      new_stop = es || (m_stop && m_cur != 0);
      new_tgt  = (es || m_stop) ? 0 : (acc ? clampi(spd, SL) : m_tgt);
      m_cur  = new_cur;
      m_tgt  = new_tgt;
      m_stop = new_stop;
      m_k    = (m_k + 1) % P;
      m_sync = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while (!(m_cur == m_tgt && !m_busy && !m_we) && n < 300) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    chk({tag, "_settle"}, n < 300, 1);
    idle(2);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    wr_cyc.delete();
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    int n, mx;
    bit es_lvl;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_at_target", at_target, 1);

    // 1: post-reset sync write
    clear_obs();
    cycle(0, 0, 0, 0);
    idle(6);
    exp_q = '{0};
    check_writes("t1");
    chk("t1_ready", cmd_ready, 1);
    chk("t1_busy", busy, 0);

    // 2: ramp to 250
    clear_obs();
    cycle(0, 1, 250, 0);
    settle("t2");
    exp_q = '{100, 200, 250};
    check_writes("t2");
    for (int i = 1; i < wr_cyc.size(); i++) chk("t2_gap", wr_cyc[i] - wr_cyc[i-1], 4);
    chk("t2_at_target", at_target, 1);
    chk("t2_busy", busy, 0);

    // 4: 250 -> -150 across zero
    clear_obs();
    cycle(0, 1, -150, 0);
    settle("t4");
    exp_q = '{150, 50, -50, -150};
    check_writes("t4");
    if (obs_q.size() >= 3) chk("t4_zero_cross", obs_q[2] - obs_q[1], -100);

    cycle(0, 1, 0, 0);
    settle("t4_back");

    // 3: clamp 5000 to 1000
    clear_obs();
    cycle(0, 1, 5000, 0);
    settle("t3");
    exp_q.delete();
    for (int i = 1; i <= 10; i++) exp_q.push_back(100 * i);
    check_writes("t3");
    mx = -100000;
    foreach (obs_q[i]) if (obs_q[i] > mx) mx = obs_q[i];
    chk("t3_max_ok", mx <= 1000, 1);

    // 5: estop at 600 during ramp to 1000
    cycle(0, 1, 0, 0);
    settle("t5_pre");
    cycle(0, 1, 1000, 0);
    n = 0;
    while (m_cur != 600 && n < 200) begin cycle(0, 0, 0, 0); n++; end
    chk("t5_reach600", n < 200, 1);
    clear_obs();
    cycle(0, 0, 0, 1);
    chk("t5_ready_low", cmd_ready, 0);
    cycle(0, 1, 900, 1);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1);
    exp_q = '{600, 500, 400, 300, 200, 100, 0};
    check_writes("t5");
    chk("t5_stop_busy", busy, 1);
    idle(3);
    chk("t5_ready_back", cmd_ready, 1);
    chk("t5_idle", busy, 0);

    // 6: accept on tick cycle, then reset mid-ramp
    cycle(0, 1, 500, 0);
    n = 0;
    while (m_cur != 200 && n < 100) begin cycle(0, 0, 0, 0); n++; end
    n = 0;
    while (m_k != P - 1 && n < 10) begin cycle(0, 0, 0, 0); n++; end
    clear_obs();
    cycle(0, 1, -300, 0);
    idle(5);
    exp_q = '{300, 200};
    check_writes("t6");
    cycle(1, 0, 0, 0);
    chk("t6_rst_at", at_target, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wdata", wdata, 0);
    chk("t6_rst_ready", cmd_ready, 0);
    clear_obs();
    cycle(0, 0, 0, 0);
    exp_q = '{0};
    check_writes("t6_sync");

    // Randomized traffic against the model
    es_lvl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) es_lvl = !es_lvl;
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 4000)) - 2000, es_lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
